// File: rtl/multicore_mem_arbiter_if.sv
// Native picorv32-style memory bus bundle for the multicore arbiter.
//   up_*  : N per-core request/response ports, core i in slice i
//   dn_*  : single shared-memory port
//   slave : arbiter view (serves cores, drives shared memory)
//   master: environment view (cores plus shared memory)
interface multicore_mem_arbiter_if #(
   parameter int unsigned N = 2
);
   logic [N-1:0]      up_mem_valid;
   logic [N-1:0]      up_mem_instr;
   logic [32*N-1:0]   up_mem_addr;
   logic [32*N-1:0]   up_mem_wdata;
   logic [4*N-1:0]    up_mem_wstrb;
   logic [N-1:0]      up_mem_ready;
   logic [32*N-1:0]   up_mem_rdata;

   logic              dn_mem_valid;
   logic              dn_mem_instr;
   logic [31:0]       dn_mem_addr;
   logic [31:0]       dn_mem_wdata;
   logic [3:0]        dn_mem_wstrb;
   logic              dn_mem_ready;
   logic [31:0]       dn_mem_rdata;

   modport slave (
      input  up_mem_valid, up_mem_instr, up_mem_addr, up_mem_wdata, up_mem_wstrb,
      output up_mem_ready, up_mem_rdata,
      output dn_mem_valid, dn_mem_instr, dn_mem_addr, dn_mem_wdata, dn_mem_wstrb,
      input  dn_mem_ready, dn_mem_rdata
   );

   modport master (
      output up_mem_valid, up_mem_instr, up_mem_addr, up_mem_wdata, up_mem_wstrb,
      input  up_mem_ready, up_mem_rdata,
      input  dn_mem_valid, dn_mem_instr, dn_mem_addr, dn_mem_wdata, dn_mem_wstrb,
      output dn_mem_ready, dn_mem_rdata
   );
endinterface

// File: rtl/multicore_mem_arbiter.sv
// Round-robin arbiter from N core memory ports onto one shared memory port.
// Each core owns a WINDOW_BYTES window, relocated to core_index*WINDOW_BYTES.
// Out-of-window accesses complete locally with rdata 0 and set a sticky err.
//   clk, resetn : clock, async active-low reset
//   bus         : up_* core ports and dn_* shared-memory port (slave modport)
//   grant_idx   : core currently owning the bus
//   busy        : high whenever a transaction is being handled
//   err         : sticky per-core out-of-window flag
module multicore_mem_arbiter #(
   parameter int unsigned N            = 2,
   parameter int unsigned WINDOW_BYTES = 1024
) (
   input  logic                                  clk,
   input  logic                                  resetn,
   multicore_mem_arbiter_if.slave                bus,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0]  grant_idx,
   output logic                                  busy,
   output logic [N-1:0]                          err
);
   localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

   state_t          state;
   logic [GW-1:0]   rr_ptr;
   logic [N-1:0]    up_ready_q;
   logic [32*N-1:0] up_rdata_q;
   logic            dn_valid_q;
   logic            dn_instr_q;
   logic [31:0]     dn_addr_q;
   logic [31:0]     dn_wdata_q;
   logic [3:0]      dn_wstrb_q;

   logic [2*N-1:0]  req_rot;
   logic            win_found;
   logic [GW-1:0]   win_idx;
   logic            win_instr;
   logic [31:0]     win_addr;
   logic [31:0]     win_wdata;
   logic [3:0]      win_wstrb;
   logic            win_in_window;
   logic [31:0]     win_reloc;
   logic [GW-1:0]   rr_next;
   int unsigned     pos;

   // Round-robin winner: rotate requests so rr_ptr lands on bit 0, take the lowest set bit.
   always_comb begin
      req_rot   = {bus.up_mem_valid, bus.up_mem_valid} >> rr_ptr;
      win_found = 1'b0;
      pos       = 32'(rr_ptr);
      for (int k = int'(N) - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            win_found = 1'b1;
            pos       = 32'(rr_ptr) + 32'(k);
         end
      end
      if (pos >= N) pos = pos - N;
      win_idx   = GW'(pos);

      win_instr = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      win_wstrb = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (GW'(i) == win_idx) begin
            win_instr = bus.up_mem_instr[i];
            win_addr  = bus.up_mem_addr[32*i +: 32];
            win_wdata = bus.up_mem_wdata[32*i +: 32];
            win_wstrb = bus.up_mem_wstrb[4*i +: 4];
         end
      end
      win_in_window = (win_addr < 32'(WINDOW_BYTES));
      // 32-bit wrap on relocation is intentional
      win_reloc     = win_addr + (32'(win_idx) * 32'(WINDOW_BYTES));
      rr_next       = (grant_idx == GW'(N - 1)) ? '0 : grant_idx + 1'b1;
   end

   // Arbitration FSM with all outputs registered.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         grant_idx  <= '0;
         busy       <= 1'b0;
         err        <= '0;
         up_ready_q <= '0;
         up_rdata_q <= '0;
         dn_valid_q <= 1'b0;
         dn_instr_q <= 1'b0;
         dn_addr_q  <= '0;
         dn_wdata_q <= '0;
         dn_wstrb_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  grant_idx <= win_idx;
                  busy      <= 1'b1;
                  if (win_in_window) begin
                     dn_valid_q <= 1'b1;
                     dn_instr_q <= win_instr;
                     dn_addr_q  <= win_reloc;
                     dn_wdata_q <= win_wdata;
                     dn_wstrb_q <= win_wstrb;
                     state      <= ISSUE;
                  end else begin
                     for (int i = 0; i < int'(N); i++) begin
                        if (GW'(i) == win_idx) begin
                           err[i]                  <= 1'b1;
                           up_ready_q[i]           <= 1'b1;
                           up_rdata_q[32*i +: 32]  <= '0;
                        end
                     end
                     state <= RESP;
                  end
               end
            end
            ISSUE: begin
               if (bus.dn_mem_ready) begin
                  dn_valid_q <= 1'b0;
                  for (int i = 0; i < int'(N); i++) begin
                     if (GW'(i) == grant_idx) begin
                        up_ready_q[i]          <= 1'b1;
                        up_rdata_q[32*i +: 32] <= bus.dn_mem_rdata;
                     end
                  end
                  state <= RESP;
               end
            end
            RESP: begin
               up_ready_q <= '0;
               rr_ptr     <= rr_next;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.up_mem_ready = up_ready_q;
   assign bus.up_mem_rdata = up_rdata_q;
   assign bus.dn_mem_valid = dn_valid_q;
   assign bus.dn_mem_instr = dn_instr_q;
   assign bus.dn_mem_addr  = dn_addr_q;
   assign bus.dn_mem_wdata = dn_wdata_q;
   assign bus.dn_mem_wstrb = dn_wstrb_q;
endmodule
